watchdog2: RTL and testbench
============================

Name: watchdog2

Overview:
- Second-generation CPLD watchdog on the 8-bit CSR bus.
- Counter width is parametrised (CNT_W, 9..16 bits), with a 16-bit timeout split over two registers.
- Adds a pretimeout interrupt with a pending/status register, an atomic counter snapshot read, and an explicit state machine.
- Retains the existing features: lock bit, failsafe/recovery mode with reset-surviving counter, per-output enables, and a magic-value kick.

Parameters:
- BASE_ADDR, 5'h0: base of the 9-register window; must be ≤ 5'h17.
- CNT_W, 16: counter and timeout width, legal range 9..16.
- DFL_TIMEOUT, {CNT_W{1'b1}}: reset value of TOUT.
- DFL_OE, 2'b00: reset value of CTRL.oe.
- KICK_VALUE, 8'h6b: magic byte that must be written to KICK.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- csr_a, input, 5: register address.
- csr_di, input, 8: write data.
- csr_we, input, 1: write strobe, one cycle.
- csr_re, input, 1: read strobe, one cycle, qualifies side-effect reads.
- csr_do, output, 8: read data, combinational from csr_a; 0 for unmapped addresses.
- wdt_ce, input, 1: count-enable tick.
- wdt_out, output, 2: bite outputs, each gated by CTRL.oe.
- force_recovery_mode, output, 1: equals CTRL.en[1].
- irq_out, output, 1: STATUS.pre_pend & CTRL.irq_en.

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0 CTRL: [7:6] oe, [3] irq_en, [2] locked, [1:0] en.
  - 1 TOUT_L: TOUT[7:0].
  - 2 TOUT_H: TOUT[CNT_W-1:8]; unused upper bits read 0.
  - 3 KICK: write-only.
  - 4 CNT_L: cnt[7:0].
  - 5 CNT_H: snapshot register.
  - 6 PRE: 8-bit pretimeout threshold.
  - 7 STATUS: [1] bitten (RO), [0] pre_pend (write 1 to clear).
  - 8 WIN: see optional feature.
- Reset values: en=0, oe=DFL_OE, irq_en=0, locked=0, TOUT=DFL_TIMEOUT, PRE=0, pre_pend=0, snap=0, state=DISABLED, cnt=DFL_TIMEOUT. All outputs therefore start at 0 except wdt_out, which reflects cnt==0.
- Failsafe reset: if en[1]=1 when rst asserts, cnt and the bitten condition are preserved; every other register resets.
- Lock: while locked=1, writes to CTRL, TOUT_L/H, PRE and WIN are ignored. KICK writes and STATUS write-1-to-clear still act. Only rst clears locked.
- Kick: a write to KICK with data == KICK_VALUE loads cnt <= TOUT and sets state=RUNNING if en!=0. Any other data is ignored.
- Enable transition: writing CTRL so en goes from 00 to nonzero loads cnt <= TOUT and enters RUNNING on the next cycle. Writing en=00 enters DISABLED with cnt frozen.
- State machine: DISABLED, RUNNING, PRETIMEOUT, BITTEN.
  - RUNNING and PRETIMEOUT: on wdt_ce, cnt <= cnt-1.
  - When the decremented value ≤ {0,PRE} and PRE != 0: RUNNING -> PRETIMEOUT and pre_pend <= 1, in the same cycle.
  - When the decremented value == 0: go to BITTEN. Counting stops; there is no wrap-around.
  - A kick from any enabled state returns to RUNNING.
- Bite: bite = (cnt==0). wdt_out = oe & {2{bite}}. STATUS.bitten = bite. Bite clears one cycle after a kick.
- Priority within one cycle: rst > kick > CTRL enable-load > wdt_ce decrement.
  - Kick and wdt_ce together: the reload wins and the tick is lost.
  - W1C and a new pre_pend set in the same cycle: the set wins.
- Snapshot read: csr_re at CNT_L latches snap <= cnt[CNT_W-1:8]. CNT_H returns snap, not the live counter.
- Writing TOUT while counting does not affect the current cnt; the new value applies at the next kick.
- Latency:
  - Register write takes effect on the next clk edge.
  - wdt_out rises the cycle after the final decrementing tick.
  - irq_out asserts the cycle after the threshold-crossing tick.

Optional Feature:
- Macro: WATCHDOG2_WINDOW_EN.
- With the macro: WIN register (reset 8'hff, lockable). A valid kick while cnt[CNT_W-1:CNT_W-8] > WIN is an early kick. An early kick forces cnt <= 0 (immediate bite, state BITTEN) instead of reloading.
- Without the macro: WIN reads 0, writes are ignored, and all valid kicks reload.

Decomposition:
- Package watchdog2_pkg:
  - register offset constants (R_CTRL..R_WIN);
  - CTRL bit-position constants;
  - STATUS bit-position constants;
  - state enum type wdt_state_t.
- Sub-module wdt_down_counter: CNT_W-wide loadable down-counter with saturate-at-zero, load and ce inputs, and zero/≤threshold compare outputs.
- Top level keeps the CSR decode, lock logic and state machine.

Test Plan (all with CNT_W=16):
- Enable and bite: rst; write TOUT=16'h0004; CTRL=8'h41 (oe=01, en=01); apply 4 wdt_ce -> wdt_out=2'b01 one cycle after the 4th tick, cnt stays 0 on further ticks.
- Kick handling:
  - Write KICK=8'h6b at cnt=2 together with wdt_ce -> cnt=4, no decrement that cycle.
  - Write KICK=8'h6a -> ignored.
- Pretimeout: PRE=3, irq_en=1, TOUT=10, 7 ticks -> pre_pend=1 and irq_out=1. Write STATUS=1 -> irq_out=0. A kick keeps it clear until the next crossing.
- Lock: CTRL=8'h05, then write TOUT_L=8'h00 and CTRL=0 -> both ignored; KICK still reloads.
- Failsafe reset: en=2'b10, cnt=16'h1234 at the moment rst pulses -> cnt holds 16'h1234, en=0, force_recovery_mode=0. CNT_L read with csr_re, then CNT_H -> 8'h34, 8'h12.
- Window mode (WATCHDOG2_WINDOW_EN defined): WIN=8'h00, TOUT=16'h0300, kick at cnt=16'h0250 -> cnt=0, wdt_out asserted next cycle. Macro undefined, same stimulus -> cnt=16'h0300.

Source files
------------

// File: rtl/watchdog2_pkg.sv
// watchdog2_pkg: register offsets, CTRL/STATUS bit positions and the watchdog state type.
package watchdog2_pkg;
  localparam logic [4:0] R_CTRL   = 5'd0;
  localparam logic [4:0] R_TOUT_L = 5'd1;
  localparam logic [4:0] R_TOUT_H = 5'd2;
  localparam logic [4:0] R_KICK   = 5'd3;
  localparam logic [4:0] R_CNT_L  = 5'd4;
  localparam logic [4:0] R_CNT_H  = 5'd5;
  localparam logic [4:0] R_PRE    = 5'd6;
  localparam logic [4:0] R_STATUS = 5'd7;
  localparam logic [4:0] R_WIN    = 5'd8;
  localparam int C_EN   = 0;
  localparam int C_LOCK = 2;
  localparam int C_IRQ  = 3;
  localparam int C_OE   = 6;
  localparam int S_PEND = 0;
  localparam int S_BIT  = 1;
  typedef enum logic [1:0] {DISABLED, RUNNING, PRETIMEOUT, BITTEN} wdt_state_t;
endpackage

// File: rtl/wdt_down_counter.sv
// wdt_down_counter: loadable saturating down-counter; hold_rst keeps the count through rst.
module wdt_down_counter #(
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             ce,
  input  logic [CNT_W-1:0] thr,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             nxt_zero,
  output logic             nxt_le_thr
);
  logic [CNT_W-1:0] cnt_q, cnt_d, dec;
  always_comb begin
    zero       = cnt_q == '0;
    dec        = zero ? '0 : cnt_q - 1'b1;
    nxt_zero   = dec == '0;
    nxt_le_thr = dec <= thr;
    cnt_d      = rst ? (hold_rst ? cnt_q : RST_VAL) : load ? load_val : ce ? dec : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/watchdog2.sv
// watchdog2: CSR-mapped watchdog with pretimeout irq, counter snapshot and failsafe reset.
// Optional kick window enabled by defining WATCHDOG2_WINDOW_EN.
module watchdog2 import watchdog2_pkg::*; #(
  parameter logic [4:0]       BASE_ADDR   = 5'h0,
  parameter int               CNT_W       = 16,
  parameter logic [CNT_W-1:0] DFL_TIMEOUT = {CNT_W{1'b1}},
  parameter logic [1:0]       DFL_OE      = 2'b00,
  parameter logic [7:0]       KICK_VALUE  = 8'h6b
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] csr_a,
  input  logic [7:0] csr_di,
  input  logic       csr_we,
  input  logic       csr_re,
  output logic [7:0] csr_do,
  input  logic       wdt_ce,
  output logic [1:0] wdt_out,
  output logic       force_recovery_mode,
  output logic       irq_out
);
  logic [1:0] oe_q, oe_d, en_q, en_d;
  logic irq_en_q, irq_en_d, locked_q, locked_d, pre_pend_q, pre_pend_d;
  logic [CNT_W-1:0] tout_q, tout_d, cnt, load_val;
  logic [7:0] pre_q, pre_d, snap_q, snap_d, rdata, status;
  wdt_state_t state_q, state_d;
  logic [5:0] diff;
  logic [4:0] off;
  logic hit, wr, cfg_wr, ctrl_wr, kick, en_load, dis_wr, counting, cnt_load, cnt_ce;
  logic crossing, early, zero, nxt_zero, nxt_le;
`ifdef WATCHDOG2_WINDOW_EN
  logic [7:0] win_q, win_d;
`endif
  wdt_down_counter #(.CNT_W(CNT_W), .RST_VAL(DFL_TIMEOUT)) u_cnt (
    .clk(clk), .rst(rst), .hold_rst(en_q[1]), .load(cnt_load), .load_val(load_val),
    .ce(cnt_ce), .thr(CNT_W'(pre_q)), .cnt(cnt), .zero(zero), .nxt_zero(nxt_zero),
    .nxt_le_thr(nxt_le)
  );
  always_comb begin
    diff     = {1'b0, csr_a} - {1'b0, BASE_ADDR};
    off      = diff[4:0];
    hit      = diff <= 6'd8;
    wr       = csr_we && hit;
    cfg_wr   = wr && !locked_q;
    ctrl_wr  = cfg_wr && off == R_CTRL;
    kick     = wr && off == R_KICK && csr_di == KICK_VALUE && en_q != 2'b00;
    en_load  = ctrl_wr && en_q == 2'b00 && csr_di[C_EN+:2] != 2'b00;
    dis_wr   = ctrl_wr && csr_di[C_EN+:2] == 2'b00;
    counting = state_q == RUNNING || state_q == PRETIMEOUT;
    cnt_load = kick || en_load;
    cnt_ce   = wdt_ce && counting && !cnt_load && !dis_wr;
    crossing = nxt_le && pre_q != 8'd0;
`ifdef WATCHDOG2_WINDOW_EN
    early    = cnt[CNT_W-1:CNT_W-8] > win_q;
    win_d    = cfg_wr && off == R_WIN ? csr_di : win_q;
`else
    early    = 1'b0;
`endif
    load_val = kick && early ? '0 : tout_q;
    oe_d     = ctrl_wr ? csr_di[C_OE+:2] : oe_q;
    irq_en_d = ctrl_wr ? csr_di[C_IRQ] : irq_en_q;
    locked_d = ctrl_wr ? csr_di[C_LOCK] : locked_q;
    en_d     = ctrl_wr ? csr_di[C_EN+:2] : en_q;
    pre_d    = cfg_wr && off == R_PRE ? csr_di : pre_q;
    tout_d   = tout_q;
    if (cfg_wr && off == R_TOUT_L) tout_d[7:0] = csr_di;
    if (cfg_wr && off == R_TOUT_H) tout_d[CNT_W-1:8] = csr_di[CNT_W-9:0];
    // a fresh crossing outranks a simultaneous write-1-to-clear
    pre_pend_d = (cnt_ce && state_q == RUNNING && crossing) ||
                 (pre_pend_q && !(wr && off == R_STATUS && csr_di[S_PEND]));
    state_d = dis_wr ? DISABLED : kick ? (early ? BITTEN : RUNNING) : en_load ? RUNNING :
              !cnt_ce ? state_q : nxt_zero ? BITTEN :
              (state_q == RUNNING && crossing) ? PRETIMEOUT : state_q;
    snap_d  = csr_re && hit && off == R_CNT_L ? 8'(cnt[CNT_W-1:8]) : snap_q;
    status  = 8'd0;
    status[S_BIT]  = zero;
    status[S_PEND] = pre_pend_q;
    rdata = 8'd0;
    if (hit)
      case (off)
        R_CTRL:   rdata = {oe_q, 2'b00, irq_en_q, locked_q, en_q};
        R_TOUT_L: rdata = tout_q[7:0];
        R_TOUT_H: rdata = 8'(tout_q[CNT_W-1:8]);
        R_CNT_L:  rdata = cnt[7:0];
        R_CNT_H:  rdata = snap_q;
        R_PRE:    rdata = pre_q;
        R_STATUS: rdata = status;
`ifdef WATCHDOG2_WINDOW_EN
        R_WIN:    rdata = win_q;
`endif
        default:  rdata = 8'd0;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q       <= DFL_OE;
      irq_en_q   <= 1'b0;
      locked_q   <= 1'b0;
      en_q       <= 2'b00;
      tout_q     <= DFL_TIMEOUT;
      pre_q      <= 8'd0;
      pre_pend_q <= 1'b0;
      snap_q     <= 8'd0;
      state_q    <= DISABLED;
`ifdef WATCHDOG2_WINDOW_EN
      win_q      <= 8'hff;
`endif
    end else begin
      oe_q       <= oe_d;
      irq_en_q   <= irq_en_d;
      locked_q   <= locked_d;
      en_q       <= en_d;
      tout_q     <= tout_d;
      pre_q      <= pre_d;
      pre_pend_q <= pre_pend_d;
      snap_q     <= snap_d;
      state_q    <= state_d;
`ifdef WATCHDOG2_WINDOW_EN
      win_q      <= win_d;
`endif
    end
  end
  assign csr_do              = rdata;
  assign wdt_out             = oe_q & {2{zero}};
  assign force_recovery_mode = en_q[1];
  assign irq_out             = pre_pend_q & irq_en_q;
endmodule

// File: tb/tb_watchdog2.sv
// tb_watchdog2: directed checks of watchdog2 (CNT_W=16) against hand-computed values.
module tb_watchdog2;
  logic clk = 1'b0, rst = 1'b1, csr_we = 1'b0, csr_re = 1'b0, wdt_ce = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0, csr_do, d;
  logic [1:0] wdt_out;
  logic force_recovery_mode, irq_out;
  logic [15:0] c;
  int n_tests = 0, n_fail = 0;
  watchdog2 dut (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we), .csr_re(csr_re),
    .csr_do(csr_do), .wdt_ce(wdt_ce), .wdt_out(wdt_out),
    .force_recovery_mode(force_recovery_mode), .irq_out(irq_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    csr_a = a; csr_di = v; csr_we = 1'b1;
    @(posedge clk); #1 csr_we = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    csr_a = a; csr_re = 1'b1;
    #1 v = csr_do;
    @(posedge clk); #1 csr_re = 1'b0;
  endtask
  task automatic rd_cnt(output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(5'd4, lo);
    rd(5'd5, hi);
    v = {hi, lo};
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      wdt_ce = 1'b1;
      @(posedge clk); #1 wdt_ce = 1'b0;
    end
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_wdt_out", 16'(wdt_out), 16'h0);
    check("rst_irq", 16'(irq_out), 16'h0);
    check("rst_frm", 16'(force_recovery_mode), 16'h0);
    rd(5'd0, d); check("rst_ctrl", 16'(d), 16'h00);
    rd(5'd1, d); check("rst_tout_l", 16'(d), 16'hff);
    rd(5'd2, d); check("rst_tout_h", 16'(d), 16'hff);
    rd(5'd7, d); check("rst_status", 16'(d), 16'h00);
    rd(5'd9, d); check("unmapped", 16'(d), 16'h00);
    rd_cnt(c); check("rst_cnt", c, 16'hffff);
    // enable and bite
    wr(5'd1, 8'h04); wr(5'd2, 8'h00); wr(5'd0, 8'h41);
    tick(3); check("pre_bite", 16'(wdt_out), 16'h0);
    tick(1); check("bite", 16'(wdt_out), 16'h1);
    rd(5'd7, d); check("status_bitten", 16'(d), 16'h02);
    tick(2); rd_cnt(c); check("sat_zero", c, 16'h0000);
    // kick handling
    wr(5'd3, 8'h6b); check("kick_unbite", 16'(wdt_out), 16'h0);
    tick(2);
    csr_a = 5'd3; csr_di = 8'h6b; csr_we = 1'b1; wdt_ce = 1'b1;
    @(posedge clk); #1 csr_we = 1'b0; wdt_ce = 1'b0;
    rd_cnt(c); check("kick_with_ce", c, 16'h0004);
    tick(1); wr(5'd3, 8'h6a);
    rd_cnt(c); check("bad_kick", c, 16'h0003);
    // pretimeout
    wr(5'd6, 8'h03); wr(5'd1, 8'h0a); wr(5'd0, 8'h49); wr(5'd3, 8'h6b);
    tick(6); check("irq_before", 16'(irq_out), 16'h0);
    tick(1); check("irq_cross", 16'(irq_out), 16'h1);
    rd(5'd7, d); check("status_pend", 16'(d), 16'h01);
    wr(5'd7, 8'h01); check("irq_w1c", 16'(irq_out), 16'h0);
    wr(5'd3, 8'h6b); tick(6); check("irq_kept_clear", 16'(irq_out), 16'h0);
    tick(1); check("irq_recross", 16'(irq_out), 16'h1);
    wr(5'd7, 8'h01); tick(1); check("irq_no_reset_in_pre", 16'(irq_out), 16'h0);
    // lock
    wr(5'd0, 8'h05); rd(5'd0, d); check("lock_ctrl", 16'(d), 16'h05);
    wr(5'd1, 8'h00); wr(5'd0, 8'h00);
    rd(5'd0, d); check("lock_ctrl_held", 16'(d), 16'h05);
    rd(5'd1, d); check("lock_tout_held", 16'(d), 16'h0a);
    tick(1); wr(5'd3, 8'h6b);
    rd_cnt(c); check("lock_kick", c, 16'h000a);
    // failsafe reset
    pulse_rst();
    rd_cnt(c); check("plain_rst_cnt", c, 16'hffff);
    rd(5'd0, d); check("unlock_by_rst", 16'(d), 16'h00);
    wr(5'd1, 8'h34); wr(5'd2, 8'h12); wr(5'd0, 8'h02);
    check("frm_on", 16'(force_recovery_mode), 16'h1);
    pulse_rst();
    check("frm_off", 16'(force_recovery_mode), 16'h0);
    rd(5'd0, d); check("fs_ctrl", 16'(d), 16'h00);
    tick(1);
    rd(5'd4, d); check("fs_cnt_l", 16'(d), 16'h34);
    rd(5'd5, d); check("fs_cnt_h", 16'(d), 16'h12);
    rd(5'd1, d); check("fs_tout_l", 16'(d), 16'hff);
    // window
    pulse_rst();
    rd(5'd8, d);
`ifdef WATCHDOG2_WINDOW_EN
    check("win_rst", 16'(d), 16'hff);
`else
    check("win_rst", 16'(d), 16'h00);
`endif
    wr(5'd1, 8'h50); wr(5'd2, 8'h02); wr(5'd0, 8'h41);
    wr(5'd8, 8'h00); wr(5'd1, 8'h00); wr(5'd2, 8'h03);
    rd_cnt(c); check("tout_no_effect", c, 16'h0250);
    wr(5'd3, 8'h6b);
`ifdef WATCHDOG2_WINDOW_EN
    check("early_bite", 16'(wdt_out), 16'h1);
    rd_cnt(c); check("early_cnt", c, 16'h0000);
`else
    check("no_window_bite", 16'(wdt_out), 16'h0);
    rd_cnt(c); check("no_window_cnt", c, 16'h0300);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
